// File: rtl/turf_fragment_arbiter.sv
// Round-robin arbiter that shares one UDP header + payload output among NSRC fragment sources.
// Each grant covers a whole fragment: one header beat, then payload beats through tlast.
module turf_fragment_arbiter #(
    parameter int NSRC = 2,
    parameter int CNTW = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NSRC-1:0]      src_enable_i,
    input  logic [64*NSRC-1:0]   s_hdr_tdata,
    input  logic [16*NSRC-1:0]   s_hdr_tuser,
    input  logic [NSRC-1:0]      s_hdr_tvalid,
    output logic [NSRC-1:0]      s_hdr_tready,
    input  logic [64*NSRC-1:0]   s_payload_tdata,
    input  logic [8*NSRC-1:0]    s_payload_tkeep,
    input  logic [NSRC-1:0]      s_payload_tuser,
    input  logic [NSRC-1:0]      s_payload_tlast,
    input  logic [NSRC-1:0]      s_payload_tvalid,
    output logic [NSRC-1:0]      s_payload_tready,
    output logic [63:0]          m_hdr_tdata,
    output logic [15:0]          m_hdr_tuser,
    output logic                 m_hdr_tvalid,
    input  logic                 m_hdr_tready,
    output logic [63:0]          m_payload_tdata,
    output logic [7:0]           m_payload_tkeep,
    output logic                 m_payload_tuser,
    output logic                 m_payload_tlast,
    output logic                 m_payload_tvalid,
    input  logic                 m_payload_tready,
    output logic [NSRC-1:0]      grant_o,
    output logic                 busy_o,
    input  logic [1:0]           count_sel_i,
    output logic [CNTW-1:0]      count_o
);
    // state   | meaning
    // IDLE    | no grant; pick the next requester in round-robin order
    // HDR     | granted source's header routed to m_hdr, waiting for its handshake
    // PAYLOAD | granted source's payload routed to m_payload until tlast handshake
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t          state;
    logic [NSRC-1:0] grant;
    logic            busy;
    logic [PW-1:0]   rr_ptr;
    logic [CNTW-1:0] cnt [NSRC];

    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] pick;
    logic            pick_any;
    logic [PW-1:0]   rr_after;
    logic [CNTW-1:0] cnt_mux;
    logic            hdr_fire;
    logic            pay_done;

    // First requester at or after the rr pointer, wrapping at NSRC-1.
    always_comb begin
        cand     = s_hdr_tvalid & src_enable_i;
        pick     = '0;
        pick_any = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (!pick_any && cand[(int'(rr_ptr) + k) % NSRC]) begin
                pick_any                             = 1'b1;
                pick[(int'(rr_ptr) + k) % NSRC]      = 1'b1;
            end
        end
    end

    always_comb begin
        rr_after = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                rr_after = (i == NSRC - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_comb begin
        m_hdr_tdata     = '0;
        m_hdr_tuser     = '0;
        m_payload_tdata = '0;
        m_payload_tkeep = '0;
        m_payload_tuser = 1'b0;
        m_payload_tlast = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                m_hdr_tdata     = s_hdr_tdata[i*64 +: 64];
                m_hdr_tuser     = s_hdr_tuser[i*16 +: 16];
                m_payload_tdata = s_payload_tdata[i*64 +: 64];
                m_payload_tkeep = s_payload_tkeep[i*8 +: 8];
                m_payload_tuser = s_payload_tuser[i];
                m_payload_tlast = s_payload_tlast[i];
            end
        end
        m_hdr_tvalid     = (state == HDR) && |(grant & s_hdr_tvalid);
        m_payload_tvalid = (state == PAYLOAD) && |(grant & s_payload_tvalid);
        s_hdr_tready     = (state == HDR) ? (grant & {NSRC{m_hdr_tready}}) : '0;
        s_payload_tready = (state == PAYLOAD) ? (grant & {NSRC{m_payload_tready}}) : '0;
    end

    always_comb begin
        cnt_mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (count_sel_i == 2'(i)) begin
                cnt_mux = cnt[i];
            end
        end
    end

    assign hdr_fire = m_hdr_tvalid && m_hdr_tready;
    assign pay_done = m_payload_tvalid && m_payload_tready && m_payload_tlast;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            rr_ptr  <= '0;
            count_o <= '0;
            for (int i = 0; i < NSRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            count_o <= cnt_mux;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        busy  <= 1'b1;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_fire) begin
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (pay_done) begin
                        for (int i = 0; i < NSRC; i++) begin
                            if (grant[i]) begin
                                cnt[i] <= cnt[i] + CNTW'(1);
                            end
                        end
                        rr_ptr <= rr_after;
                        grant  <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o = grant;
    assign busy_o  = busy;

endmodule

// File: tb/tb_turf_fragment_arbiter.sv
// Scoreboard bench for turf_fragment_arbiter: random fragment sources, per-source expected
// queues, and a round-robin / counter reference model evaluated on the output handshakes.
module tb_turf_fragment_arbiter;
    localparam int NSRC = 2;
    localparam int CNTW = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [15:0] user;
    } hdr_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        user;
        logic        last;
    } beat_t;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [NSRC-1:0]      src_enable_i;
    logic [64*NSRC-1:0]   s_hdr_tdata;
    logic [16*NSRC-1:0]   s_hdr_tuser;
    logic [NSRC-1:0]      s_hdr_tvalid;
    logic [NSRC-1:0]      s_hdr_tready;
    logic [64*NSRC-1:0]   s_payload_tdata;
    logic [8*NSRC-1:0]    s_payload_tkeep;
    logic [NSRC-1:0]      s_payload_tuser;
    logic [NSRC-1:0]      s_payload_tlast;
    logic [NSRC-1:0]      s_payload_tvalid;
    logic [NSRC-1:0]      s_payload_tready;
    logic [63:0]          m_hdr_tdata;
    logic [15:0]          m_hdr_tuser;
    logic                 m_hdr_tvalid;
    logic                 m_hdr_tready;
    logic [63:0]          m_payload_tdata;
    logic [7:0]           m_payload_tkeep;
    logic                 m_payload_tuser;
    logic                 m_payload_tlast;
    logic                 m_payload_tvalid;
    logic                 m_payload_tready;
    logic [NSRC-1:0]      grant_o;
    logic                 busy_o;
    logic [1:0]           count_sel_i;
    logic [CNTW-1:0]      count_o;

    turf_fragment_arbiter #(.NSRC(NSRC), .CNTW(CNTW)) dut (
        .aclk(aclk), .aresetn(aresetn), .src_enable_i(src_enable_i),
        .s_hdr_tdata(s_hdr_tdata), .s_hdr_tuser(s_hdr_tuser),
        .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready),
        .s_payload_tdata(s_payload_tdata), .s_payload_tkeep(s_payload_tkeep),
        .s_payload_tuser(s_payload_tuser), .s_payload_tlast(s_payload_tlast),
        .s_payload_tvalid(s_payload_tvalid), .s_payload_tready(s_payload_tready),
        .m_hdr_tdata(m_hdr_tdata), .m_hdr_tuser(m_hdr_tuser),
        .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
        .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
        .m_payload_tuser(m_payload_tuser), .m_payload_tlast(m_payload_tlast),
        .m_payload_tvalid(m_payload_tvalid), .m_payload_tready(m_payload_tready),
        .grant_o(grant_o), .busy_o(busy_o),
        .count_sel_i(count_sel_i), .count_o(count_o)
    );

    always #5 aclk = ~aclk;

    int tests  = 0;
    int errors = 0;

    // Scoreboard: the driver pushes each fragment as it is generated, the monitor pops.
    hdr_t  exp_hdr  [NSRC][$];
    beat_t exp_beat [NSRC][$];

    int target   [NSRC];
    int issued   [NSRC];
    int done_cnt [NSRC];
    logic [CNTW-1:0] mcnt [NSRC];

    int fixed_len  = 0;
    int nogap      = 0;
    int ready_mode = 2;
    int sel_rand   = 1;
    bit mon_en     = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source driver: inputs change 1 time unit after the rising edge, handshakes sampled at negedge.
    initial begin
        int    phase [NSRC];
        int    blen  [NSRC];
        int    bi    [NSRC];
        logic [NSRC-1:0] hh;
        logic [NSRC-1:0] ph;
        hdr_t  h;
        beat_t b;
        for (int i = 0; i < NSRC; i++) begin
            phase[i] = 0; blen[i] = 0; bi[i] = 0; issued[i] = 0;
        end
        s_hdr_tdata = '0; s_hdr_tuser = '0; s_hdr_tvalid = '0;
        s_payload_tdata = '0; s_payload_tkeep = '0; s_payload_tuser = '0;
        s_payload_tlast = '0; s_payload_tvalid = '0;
        m_hdr_tready = 1'b1; m_payload_tready = 1'b1; count_sel_i = '0;
        forever begin
            @(negedge aclk);
            hh = s_hdr_tvalid & s_hdr_tready;
            ph = s_payload_tvalid & s_payload_tready;
            @(posedge aclk);
            #1;
            case (ready_mode)
                0: begin
                    m_hdr_tready     = ($urandom_range(0, 3) != 0);
                    m_payload_tready = ($urandom_range(0, 3) != 0);
                end
                1: begin
                    m_hdr_tready     = 1'b1;
                    m_payload_tready = ~m_payload_tready;
                end
                default: begin
                    m_hdr_tready     = 1'b1;
                    m_payload_tready = 1'b1;
                end
            endcase
            if (sel_rand != 0) count_sel_i = 2'($urandom_range(0, 3));
            for (int i = 0; i < NSRC; i++) begin
                case (phase[i])
                    0: begin
                        if (issued[i] < target[i] && (nogap != 0 || $urandom_range(0, 3) != 0)) begin
                            h.data = {$urandom, $urandom};
                            h.user = 16'($urandom);
                            exp_hdr[i].push_back(h);
                            s_hdr_tdata[i*64 +: 64] = h.data;
                            s_hdr_tuser[i*16 +: 16] = h.user;
                            s_hdr_tvalid[i] = 1'b1;
                            blen[i]  = (fixed_len != 0) ? fixed_len : $urandom_range(1, 9);
                            bi[i]    = 0;
                            phase[i] = 1;
                            issued[i]++;
                        end
                    end
                    1: begin
                        if (hh[i]) begin
                            s_hdr_tvalid[i] = 1'b0;
                            phase[i] = 2;
                        end
                    end
                    default: begin
                        if (ph[i]) begin
                            s_payload_tvalid[i] = 1'b0;
                            bi[i]++;
                            if (bi[i] == blen[i]) phase[i] = 0;
                        end
                        if (phase[i] == 2 && !s_payload_tvalid[i] &&
                            (nogap != 0 || $urandom_range(0, 2) != 0)) begin
                            b.data = {$urandom, $urandom};
                            b.keep = 8'($urandom);
                            b.user = 1'($urandom);
                            b.last = (bi[i] == blen[i] - 1);
                            exp_beat[i].push_back(b);
                            s_payload_tdata[i*64 +: 64] = b.data;
                            s_payload_tkeep[i*8 +: 8]   = b.keep;
                            s_payload_tuser[i]          = b.user;
                            s_payload_tlast[i]          = b.last;
                            s_payload_tvalid[i]         = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor + reference model: round-robin order, fragment atomicity, per-source counts.
    initial begin
        logic [NSRC-1:0] exp_grant;
        logic [NSRC-1:0] cand;
        logic [NSRC-1:0] nxt;
        logic [CNTW-1:0] exp_count;
        bit              exp_valid;
        bit              in_frag;
        bit              last_hs;
        int              rr_m;
        int              g;
        int              s;
        hdr_t            h;
        beat_t           e;
        beat_t           act_b;
        exp_grant = '0; exp_count = '0; exp_valid = 1'b0; in_frag = 1'b0; rr_m = 0;
        for (int i = 0; i < NSRC; i++) begin
            mcnt[i] = '0; done_cnt[i] = 0;
        end
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                g = 0;
                for (int i = 0; i < NSRC; i++) if (exp_grant[i]) g = i;
                if (exp_valid) chk("grant", grant_o, exp_grant);
                chk("busy", busy_o, (exp_grant != 0));
                chk("ungranted_ready", {s_hdr_tready & ~exp_grant, s_payload_tready & ~exp_grant}, 0);
                chk("count", count_o, exp_count);
                if (in_frag) chk("hdr_valid_in_payload", m_hdr_tvalid, 0);
                else         chk("payload_valid_outside_frag", m_payload_tvalid, 0);
                s = int'(count_sel_i);
                exp_count = (s < NSRC) ? mcnt[s] : '0;
                last_hs = 1'b0;
                if (m_hdr_tvalid && m_hdr_tready) begin
                    if (exp_grant == 0 || in_frag || exp_hdr[g].size() == 0) begin
                        chk("spurious_hdr", 1, 0);
                    end else begin
                        h = exp_hdr[g].pop_front();
                        chk("hdr", {m_hdr_tdata, m_hdr_tuser}, h);
                        in_frag = 1'b1;
                    end
                end
                if (m_payload_tvalid && m_payload_tready) begin
                    if (!in_frag || exp_beat[g].size() == 0) begin
                        chk("spurious_payload", 1, 0);
                    end else begin
                        e = exp_beat[g].pop_front();
                        act_b = {m_payload_tdata, m_payload_tkeep, m_payload_tuser, m_payload_tlast};
                        chk("payload", act_b, e);
                        if (e.last) begin
                            last_hs     = 1'b1;
                            in_frag     = 1'b0;
                            mcnt[g]     = mcnt[g] + 1'b1;
                            rr_m        = (g + 1) % NSRC;
                            done_cnt[g] = done_cnt[g] + 1;
                        end
                    end
                end
                nxt = '0;
                if (exp_grant == 0) begin
                    cand = s_hdr_tvalid & src_enable_i;
                    for (int k = 0; k < NSRC; k++) begin
                        if (nxt == 0 && cand[(rr_m + k) % NSRC]) nxt[(rr_m + k) % NSRC] = 1'b1;
                    end
                end else if (!last_hs) begin
                    nxt = exp_grant;
                end
                exp_grant = nxt;
                exp_valid = 1'b1;
            end
        end
    end

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (c < budget) begin
            bit all_done = 1'b1;
            for (int i = 0; i < NSRC; i++) if (done_cnt[i] != target[i]) all_done = 1'b0;
            if (all_done) break;
            @(negedge aclk);
            c++;
        end
        chk(name, (c >= budget), 0);
    endtask

    task automatic wait_src0_beats(input string name, input int n);
        int nb = 0;
        int c  = 0;
        while (nb < n && c < 4000) begin
            @(negedge aclk);
            c++;
            if (grant_o[0] && m_payload_tvalid && m_payload_tready) nb++;
        end
        chk(name, (c >= 4000), 0);
    endtask

    initial begin
        for (int i = 0; i < NSRC; i++) target[i] = 0;
        aresetn = 1'b0;
        src_enable_i = '1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_readies", {s_hdr_tready, s_payload_tready}, 0);
        chk("rst_m_valid", {m_hdr_tvalid, m_payload_tvalid}, 0);
        chk("rst_count", count_o, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        mon_en  = 1'b1;

        // single src0 fragment of 4 beats, src1 idle
        fixed_len = 4; nogap = 1; ready_mode = 2;
        target[0] += 1;
        wait_done("t1_timeout", 200);

        // both sources requesting continuously: strict alternation
        fixed_len = 0;
        target[0] += 4; target[1] += 4;
        wait_done("t2_timeout", 1000);

        // 9-beat fragment under toggling payload ready
        fixed_len = 9; ready_mode = 1;
        target[0] += 1;
        wait_done("t3_timeout", 300);

        // disable src0 during beat 2 of its fragment; src1 keeps being served
        fixed_len = 5; ready_mode = 0; nogap = 0;
        target[0] += 1; target[1] += 3;
        wait_src0_beats("t4_beat_timeout", 1);
        @(posedge aclk);
        #1;
        src_enable_i[0] = 1'b0;
        wait_done("t4_timeout", 2000);
        src_enable_i = '1;

        // random traffic with random gaps and backpressure
        fixed_len = 0;
        target[0] += 15; target[1] += 15;
        wait_done("rand_timeout", 20000);

        // counter wrap on a 4-bit build, then an out-of-range selector
        fixed_len = 1; nogap = 1; ready_mode = 2;
        target[0] += 17;
        wait_done("wrap_timeout", 3000);
        sel_rand = 0;
        @(posedge aclk);
        #1;
        count_sel_i = 2'd3;
        repeat (2) @(negedge aclk);
        chk("count_sel3", count_o, 0);
        @(posedge aclk);
        #1;
        count_sel_i = 2'd0;
        repeat (2) @(negedge aclk);
        chk("count0_wrap", count_o, mcnt[0]);

        // reset during payload beat 3
        fixed_len = 6;
        target[0] += 1;
        wait_src0_beats("t5_beat_timeout", 2);
        mon_en = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_grant", grant_o, 0);
        chk("midrst_readies", {s_hdr_tready, s_payload_tready}, 0);
        chk("midrst_m_valid", {m_hdr_tvalid, m_payload_tvalid}, 0);
        src_enable_i = '0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("midrst_count0", count_o, 0);
        @(posedge aclk);
        #1;
        count_sel_i = 2'd1;
        repeat (2) @(negedge aclk);
        chk("midrst_count1", count_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
